// File: rtl/alu_op_issue.sv
// ALU operation decode and operand select, issued through a 2-entry skid buffer.
// Optional ALU_OP_ISSUE_ILLEGAL_FLAG_EN adds out_illegal and illegal_sticky outputs.
module alu_op_issue #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic                     ALUSrc,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    Imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation
`ifdef ALU_OP_ISSUE_ILLEGAL_FLAG_EN
  ,
  output logic                     out_illegal,
  output logic                     illegal_sticky
`endif
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE = OPCODE_LENGTH'(4'b1101);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    a;
    logic [DATA_WIDTH-1:0]    b;
    logic [OPCODE_LENGTH-1:0] op;
  } beat_t;

  logic [OPCODE_LENGTH-1:0] op_dec;
  logic [DATA_WIDTH-1:0]    srcb_raw;
  logic                     f7z, f7s;
  beat_t                    beat_in;

  assign f7z = (Funct7 == 7'b0000000);
  assign f7s = (Funct7 == 7'b0100000);

  always_comb begin
    op_dec = OP_ILL;
    unique case (ALUOp)
      2'b00: op_dec = OP_ADD;
      2'b01: begin
        case (Funct3)
          3'b000:  op_dec = OP_BEQ;
          3'b001:  op_dec = OP_BNE;
          3'b100:  op_dec = OP_SLT;
          3'b101:  op_dec = OP_BGE;
          default: op_dec = OP_ILL;
        endcase
      end
      2'b10: begin
        case (Funct3)
          3'b000:  op_dec = f7z ? OP_ADD : (f7s ? OP_SUB : OP_ILL);
          3'b101:  op_dec = f7z ? OP_SRL : (f7s ? OP_SRA : OP_ILL);
          3'b001:  op_dec = f7z ? OP_SLL : OP_ILL;
          3'b010:  op_dec = f7z ? OP_SLT : OP_ILL;
          3'b100:  op_dec = f7z ? OP_XOR : OP_ILL;
          3'b110:  op_dec = f7z ? OP_OR  : OP_ILL;
          3'b111:  op_dec = f7z ? OP_AND : OP_ILL;
          default: op_dec = OP_ILL;
        endcase
      end
      2'b11: begin
        // Immediate forms ignore Funct7 except for the shifts, where it selects the variant.
        case (Funct3)
          3'b000:  op_dec = OP_ADD;
          3'b010:  op_dec = OP_SLT;
          3'b100:  op_dec = OP_XOR;
          3'b110:  op_dec = OP_OR;
          3'b111:  op_dec = OP_AND;
          3'b001:  op_dec = f7z ? OP_SLL : OP_ILL;
          3'b101:  op_dec = f7z ? OP_SRL : (f7s ? OP_SRA : OP_ILL);
          default: op_dec = OP_ILL;
        endcase
      end
      default: op_dec = OP_ILL;
    endcase
  end

  assign srcb_raw = ALUSrc ? Imm : RD2;

  always_comb begin
    beat_in.a  = RD1;
    beat_in.op = op_dec;
    beat_in.b  = srcb_raw;
    if (op_dec == OP_SLL || op_dec == OP_SRL || op_dec == OP_SRA)
      beat_in.b = DATA_WIDTH'(srcb_raw[4:0]);
  end

  beat_t main_q, main_d, skid_q, skid_d;
  logic  main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, in_ready_q;
  logic  acc, cons;

  assign acc  = in_valid && in_ready_q;
  assign cons = main_vld_q && out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || cons) begin
      // Main slot frees up: skid (older) moves forward before any new beat.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_d     = acc ? beat_in : skid_q;
        skid_vld_d = acc;
      end else begin
        main_d     = acc ? beat_in : main_q;
        main_vld_d = acc;
      end
    end else if (acc) begin
      skid_d     = beat_in;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= !skid_vld_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign SrcA      = main_q.a;
  assign SrcB      = main_q.b;
  assign Operation = main_q.op;

`ifdef ALU_OP_ISSUE_ILLEGAL_FLAG_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (!reset)
      sticky_q <= 1'b0;
    else if (cons && !flush && main_q.op == OP_ILL)
      sticky_q <= 1'b1;
  end

  assign out_illegal    = (main_q.op == OP_ILL);
  assign illegal_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: decode vector table plus stall, streaming, flush and reset sequences.
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, ALUSrc, out_valid, out_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] RD1, RD2, Imm, SrcA, SrcB;
  logic [3:0]  Operation;
`ifdef ALU_OP_ISSUE_ILLEGAL_FLAG_EN
  logic        out_illegal, illegal_sticky;
`endif

  alu_op_issue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7), .ALUSrc(ALUSrc),
    .RD1(RD1), .RD2(RD2), .Imm(Imm), .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation)
`ifdef ALU_OP_ISSUE_ILLEGAL_FLAG_EN
    , .out_illegal(out_illegal), .illegal_sticky(illegal_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alusrc;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  op;
    logic [31:0] b;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  exp_t cur_exp;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare presented beat against the oldest expected beat every valid cycle.
  always @(negedge clk) begin
    if (!reset || flush) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_beat: got SrcA=%h Op=%h with nothing expected", SrcA, Operation);
        end else begin
          chk("SrcA", SrcA, q[0].a);
          chk("SrcB", SrcB, q[0].b);
          chk("Operation", 32'(Operation), 32'(q[0].op));
`ifdef ALU_OP_ISSUE_ILLEGAL_FLAG_EN
          chk("out_illegal", 32'(out_illegal), 32'(q[0].op == 4'b1111));
`endif
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input vec_t v);
    ALUOp = v.aluop; Funct3 = v.f3; Funct7 = v.f7; ALUSrc = v.alusrc;
    RD1 = v.rd1; RD2 = v.rd2; Imm = v.imm;
    cur_exp.a = v.rd1; cur_exp.b = v.b; cur_exp.op = v.op;
  endtask

  // Leaves in_valid high on return so callers can stream back-to-back.
  task automatic offer(input vec_t v, output int waits);
    bit done;
    set_beat(v);
    in_valid = 1'b1;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        waits++;
        if (waits > 50) begin
          n_tests++;
          n_fail++;
          $display("FAIL offer_timeout: in_ready stayed 0 for %0d cycles", waits);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t add_beat(input int i);
    vec_t v;
    v.aluop = 2'b00; v.f3 = 3'b000; v.f7 = 7'd0; v.alusrc = 1'b0;
    v.rd1 = 32'h1000 + 32'(i); v.rd2 = 32'(i); v.imm = 32'h0;
    v.op = 4'b0010; v.b = 32'(i);
    return v;
  endfunction

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      cyc();
      t++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  vec_t vecs[19];
  int   w, base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b10, 3'b000, 7'b0100000, 1'b0, 32'd10,         32'd3,      32'd0,          4'b0110, 32'd3};
    vecs[1]  = '{2'b11, 3'b101, 7'b0100000, 1'b1, 32'h55,         32'd9,      32'h00000423,   4'b0111, 32'h3};
    vecs[2]  = '{2'b01, 3'b110, 7'b0000000, 1'b0, 32'd7,          32'd8,      32'd0,          4'b1111, 32'd8};
    vecs[3]  = '{2'b01, 3'b001, 7'b0000000, 1'b0, 32'd7,          32'd8,      32'd0,          4'b1101, 32'd8};
    vecs[4]  = '{2'b00, 3'b111, 7'b1111111, 1'b1, 32'd100,        32'd5,      32'hFFFFFFF0,   4'b0010, 32'hFFFFFFF0};
    vecs[5]  = '{2'b10, 3'b101, 7'b0000000, 1'b0, 32'h80000000,   32'h25,     32'd0,          4'b0101, 32'h5};
    vecs[6]  = '{2'b10, 3'b001, 7'b0100000, 1'b0, 32'd1,          32'h12,     32'd0,          4'b1111, 32'h12};
    vecs[7]  = '{2'b11, 3'b001, 7'b0000000, 1'b1, 32'd2,          32'd0,      32'hFFFFFFE7,   4'b0100, 32'h7};
    vecs[8]  = '{2'b11, 3'b000, 7'b1111111, 1'b1, 32'd3,          32'd0,      32'h123,        4'b0010, 32'h123};
    vecs[9]  = '{2'b10, 3'b111, 7'b0000000, 1'b0, 32'hFF00,       32'hF0F0,   32'd0,          4'b0000, 32'hF0F0};
    vecs[10] = '{2'b11, 3'b011, 7'b0000000, 1'b1, 32'd4,          32'd0,      32'd5,          4'b1111, 32'd5};
    vecs[11] = '{2'b01, 3'b101, 7'b0000000, 1'b0, 32'd5,          32'd3,      32'd0,          4'b1001, 32'd3};
    vecs[12] = '{2'b01, 3'b100, 7'b0000000, 1'b0, 32'd6,          32'd4,      32'd0,          4'b1100, 32'd4};
    vecs[13] = '{2'b10, 3'b010, 7'b0000000, 1'b0, 32'd7,          32'd5,      32'd0,          4'b1100, 32'd5};
    vecs[14] = '{2'b10, 3'b110, 7'b0000000, 1'b0, 32'd8,          32'd6,      32'd0,          4'b0001, 32'd6};
    vecs[15] = '{2'b10, 3'b100, 7'b0000000, 1'b0, 32'd9,          32'd7,      32'd0,          4'b0011, 32'd7};
    vecs[16] = '{2'b01, 3'b000, 7'b0000000, 1'b0, 32'd11,         32'd8,      32'd0,          4'b1000, 32'd8};
    vecs[17] = '{2'b11, 3'b101, 7'b0000000, 1'b1, 32'd12,         32'd0,      32'h3F,         4'b0101, 32'h1F};
    vecs[18] = '{2'b10, 3'b000, 7'b0000000, 1'b0, 32'd13,         32'd9,      32'd0,          4'b0010, 32'd9};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = '0; Funct3 = '0; Funct7 = '0; ALUSrc = 1'b0; RD1 = '0; RD2 = '0; Imm = '0;

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_SrcA", SrcA, 32'd0);
    chk("rst_SrcB", SrcB, 32'd0);
    chk("rst_Operation", 32'(Operation), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
`ifdef ALU_OP_ISSUE_ILLEGAL_FLAG_EN
    chk("sticky_after_reset", 32'(illegal_sticky), 32'd0);
`endif
    cyc();

    // Decode table, one beat at a time, with 1-cycle latency check
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      offer(vecs[i], w);
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      cyc();
    end
    drain();
`ifdef ALU_OP_ISSUE_ILLEGAL_FLAG_EN
    chk("sticky_after_illegal", 32'(illegal_sticky), 32'd1);
`endif

    // Stall: two beats fill main+skid, the third is held off
    out_ready = 1'b0;
    base = n_out;
    offer(add_beat(1), w);
    offer(add_beat(2), w);
    set_beat(add_beat(3));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    offer(add_beat(3), w);
    in_valid = 1'b0;
    drain();
    repeat (2) cyc();
    chk("stall_beats_out", 32'(n_out - base), 32'd3);

    // Full-rate streaming
    base = n_out;
    for (int k = 0; k < 8; k++) begin
      offer(add_beat(16 + k), w);
      chk("stream_no_wait", 32'(w), 32'd0);
    end
    in_valid = 1'b0;
    drain();
    repeat (2) cyc();
    chk("stream_beats_out", 32'(n_out - base), 32'd8);

    // Flush with main and skid full, plus a beat offered during flush
    out_ready = 1'b0;
    offer(add_beat(40), w);
    offer(add_beat(41), w);
    set_beat(add_beat(42));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cyc();
    out_ready = 1'b1;
    repeat (4) cyc();

    // Reset mid-transfer discards buffered beats
    out_ready = 1'b0;
    offer(add_beat(50), w);
    offer(add_beat(51), w);
    in_valid = 1'b0;
    reset = 1'b0;
    cyc();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("midrst_after_out_valid", 32'(out_valid), 32'd0);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
